// File: rtl/tree_walk_ctrl_if.sv
// Handshake bundle between the feature front-end, one tree walker and the
// ensemble vote logic: a feature-vector input channel and a result channel.
interface tree_walk_ctrl_if #(
  parameter int NUM_FEATURES = 16,
  parameter int FEAT_WIDTH   = 64
) ();
  logic                               s_valid;
  logic                               s_ready;
  logic [NUM_FEATURES*FEAT_WIDTH-1:0] feat_in;
  logic                               res_valid;
  logic                               res_ready;
  logic [3:0]                         res_class;
  logic                               res_err;
  logic [5:0]                         res_depth;

  modport master (
    output s_valid, feat_in, res_ready,
    input  s_ready, res_valid, res_class, res_err, res_depth
  );

  modport slave (
    input  s_valid, feat_in, res_ready,
    output s_ready, res_valid, res_class, res_err, res_depth
  );
endinterface

// File: rtl/tree_walk_ctrl.sv
// tree_walk_ctrl: walks one decision tree held in a node ROM with a 1-cycle
// registered read. A feature vector is latched on accept, nodes are fetched
// from ROOT_ADDR, the selected feature is compared against each threshold in
// IEEE-754 total order (+0 == -0), and the leaf tag is returned on the result
// handshake. Walks that hit a bad feature index, an out-of-range child, or
// MAX_DEPTH internal nodes finish with res_err=1 and class 0.
// Optional: define TREE_NODE_ID_CHECK_EN to abort when a node's node_id does
// not match the address it was fetched from (ROM image/address mismatch).
module tree_walk_ctrl #(
  parameter int NODE_WIDTH   = 120,
  parameter int ADDR_WIDTH   = 10,
  parameter int ROM_DEPTH    = 512,
  parameter int NUM_FEATURES = 16,
  parameter int FEAT_WIDTH   = 64,
  parameter int MAX_DEPTH    = 32,
  parameter int ROOT_ADDR    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  tree_walk_ctrl_if.slave       io,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [NODE_WIDTH-1:0] node_data,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, FETCH, EVAL, DONE} state_t;

  state_t state, state_nxt;

  logic [NUM_FEATURES*FEAT_WIDTH-1:0] feat_q;
  logic [5:0]                         depth_q;
  logic [3:0]                         res_class_q;
  logic                               res_err_q;
  logic [5:0]                         res_depth_q;

  // Node word fields
  logic [3:0]  feat_idx;
  logic [63:0] threshold;
  logic [11:0] left_ptr;
  logic [11:0] right_ptr;
  logic [3:0]  tag;

  assign feat_idx  = node_data[95:92];
  assign threshold = node_data[91:28];
  assign left_ptr  = node_data[27:16];
  assign right_ptr = node_data[15:4];
  assign tag       = node_data[3:0];

  logic unused_node_bits;
`ifdef TREE_NODE_ID_CHECK_EN
  logic [11:0] node_id;
  assign node_id          = node_data[107:96];
  assign unused_node_bits = ^node_data[119:108];
`else
  assign unused_node_bits = ^node_data[119:96];
`endif

  // a <= b in IEEE total order on sign-magnitude words, with +0 == -0
  function automatic logic fp_le(input logic [63:0] a, input logic [63:0] b);
    logic a_zero, b_zero;
    a_zero = (a[62:0] == 63'd0);
    b_zero = (b[62:0] == 63'd0);
    if (a_zero && b_zero)    return 1'b1;
    if (a[63] != b[63])      return a[63];
    if (!a[63])              return a[62:0] <= b[62:0];
    return a[62:0] >= b[62:0];
  endfunction

  // Child pointer must fit the address bus and land inside the populated ROM
  function automatic logic child_ok(input logic [11:0] c);
    return ((int'(c) >> ADDR_WIDTH) == 0) && (int'(c) < ROM_DEPTH);
  endfunction

  logic        fidx_ok;
  logic [63:0] feat_sel;
  logic        go_left;
  logic [11:0] child_ptr;
  logic        is_leaf;
  logic        id_err;
  logic        eval_err;
  logic        eval_leaf;

  // Evaluate the node currently presented by the ROM
  always_comb begin
    fidx_ok   = int'(feat_idx) < NUM_FEATURES;
    feat_sel  = feat_q[(fidx_ok ? int'(feat_idx) : 0)*FEAT_WIDTH +: 64];
    go_left   = fp_le(feat_sel, threshold);
    child_ptr = go_left ? left_ptr : right_ptr;
    is_leaf   = (left_ptr == 12'd0) && (right_ptr == 12'd0);
    id_err    = 1'b0;
`ifdef TREE_NODE_ID_CHECK_EN
    id_err    = int'(node_id) != int'(rom_addr);
`endif
    eval_leaf = !id_err && is_leaf;
    eval_err  = id_err || (!is_leaf && (!fidx_ok || !child_ok(left_ptr) ||
                                        !child_ok(right_ptr) ||
                                        int'(depth_q) == MAX_DEPTH));
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (io.s_valid) state_nxt = FETCH;
      FETCH:   state_nxt = EVAL;
      EVAL:    if (eval_leaf || eval_err) state_nxt = DONE;
               else state_nxt = FETCH;
      DONE:    if (io.res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Feature vector is frozen at accept for the whole walk
  always_ff @(posedge clk) begin
    if (state == IDLE && io.s_valid) feat_q <= io.feat_in;
  end

  // Walk address, depth counter and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr    <= ADDR_WIDTH'(ROOT_ADDR);
      depth_q     <= 6'd0;
      res_class_q <= 4'd0;
      res_err_q   <= 1'b0;
      res_depth_q <= 6'd0;
    end else begin
      case (state)
        IDLE: begin
          if (io.s_valid) begin
            rom_addr <= ADDR_WIDTH'(ROOT_ADDR);
            depth_q  <= 6'd0;
          end
        end
        EVAL: begin
          if (eval_err) begin
            res_class_q <= 4'd0;
            res_err_q   <= 1'b1;
            res_depth_q <= depth_q;
          end else if (eval_leaf) begin
            res_class_q <= tag;
            res_err_q   <= 1'b0;
            res_depth_q <= depth_q;
          end else begin
            rom_addr <= ADDR_WIDTH'(child_ptr);
            depth_q  <= depth_q + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign io.s_ready  = (state == IDLE);
  assign io.res_valid = (state == DONE);
  assign io.res_class = res_class_q;
  assign io.res_err   = res_err_q;
  assign io.res_depth = res_depth_q;
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_tree_walk_ctrl.sv
// Testbench for tree_walk_ctrl: directed scenarios plus randomized trees
// checked against a walk model computed from the node-format rules.
module tb_tree_walk_ctrl;
  localparam int NF = 8;
  localparam int MD = 4;
  localparam int AW = 10;
  localparam int RD = 512;
  localparam int NW = 120;
  localparam int FW = 64;

  localparam logic [63:0] D_128  = 64'h4060000000000000;
  localparam logic [63:0] D_1925 = 64'h4068100000000000;
  localparam logic [63:0] D_256  = 64'h4070000000000000;
  localparam logic [63:0] D_HALF = 64'h3FE0000000000000;
  localparam logic [63:0] D_M1   = 64'hBFF0000000000000;
  localparam logic [63:0] D_M2   = 64'hC000000000000000;
  localparam logic [63:0] D_P0   = 64'h0000000000000000;
  localparam logic [63:0] D_N0   = 64'h8000000000000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [AW-1:0] rom_addr;
  logic [NW-1:0] node_data;
  logic          busy;

  tree_walk_ctrl_if #(.NUM_FEATURES(NF), .FEAT_WIDTH(FW)) tif ();

  tree_walk_ctrl #(
    .NODE_WIDTH(NW), .ADDR_WIDTH(AW), .ROM_DEPTH(RD), .NUM_FEATURES(NF),
    .FEAT_WIDTH(FW), .MAX_DEPTH(MD), .ROOT_ADDR(0)
  ) dut (
    .clk(clk), .rst(rst), .io(tif), .rom_addr(rom_addr),
    .node_data(node_data), .busy(busy)
  );

  logic [NW-1:0] rom [1024];
  always @(posedge clk) node_data <= rom[rom_addr];

  int n_pass  = 0;
  int n_total = 0;

  logic [63:0] pool [12];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [NW-1:0] mk_node(input int id, input int fidx, input logic [63:0] thr,
                                            input int l, input int r, input int tag);
    logic [NW-1:0] n;
    n = '0;
    n[119:108] = 12'hABC;
    n[107:96]  = 12'(id);
    n[95:92]   = 4'(fidx);
    n[91:28]   = thr;
    n[27:16]   = 12'(l);
    n[15:4]    = 12'(r);
    n[3:0]     = 4'(tag);
    return n;
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 1024; i++) rom[i] = mk_node(i, 0, 64'd0, 0, 0, 0);
  endtask

  function automatic logic [63:0] pick();
    return pool[$urandom_range(0, 11)];
  endfunction

  function automatic logic [NF*FW-1:0] rand_fv();
    logic [NF*FW-1:0] v;
    for (int k = 0; k < NF; k++) v[k*FW +: FW] = pick();
    return v;
  endfunction

  // Ordering key: totally ordered integer view of a double, +0 and -0 both map to 0
  function automatic longint okey(input logic [63:0] x);
    longint m;
    m = longint'({1'b0, x[62:0]});
    return x[63] ? -m : m;
  endfunction

  // Reference walk over the ROM image
  function automatic void model(input logic [NF*FW-1:0] fv, output logic [3:0] c,
                                output logic e, output logic [5:0] d);
    int addr, dd;
    logic [NW-1:0] n;
    logic [63:0] f;
    addr = 0; dd = 0; c = 4'd0; e = 1'b0; d = 6'd0;
    for (int step = 0; step < 64; step++) begin
      n = rom[addr];
`ifdef TREE_NODE_ID_CHECK_EN
      if (int'(n[107:96]) != addr) begin e = 1'b1; d = 6'(dd); return; end
`endif
      if (n[27:16] == 12'd0 && n[15:4] == 12'd0) begin c = n[3:0]; d = 6'(dd); return; end
      if (int'(n[95:92]) >= NF || int'(n[27:16]) >= RD || int'(n[15:4]) >= RD || dd == MD) begin
        e = 1'b1; d = 6'(dd); return;
      end
      f = fv[int'(n[95:92])*FW +: FW];
      addr = (okey(f) <= okey(n[91:28])) ? int'(n[27:16]) : int'(n[15:4]);
      dd++;
    end
  endfunction

  // Present one vector, scramble feat_in after accept, wait for res_valid
  task automatic run_walk(input logic [NF*FW-1:0] fv, output logic [3:0] c, output logic e,
                          output logic [5:0] d, output int lat);
    int w;
    w = 0;
    while (!tif.s_ready && w < 100) begin @(posedge clk); #1; w++; end
    tif.s_valid = 1'b1;
    tif.feat_in = fv;
    @(posedge clk); #1;
    tif.s_valid = 1'b0;
    for (int k = 0; k < NF*2; k++) tif.feat_in[k*32 +: 32] = $urandom;
    lat = 0;
    while (!tif.res_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    c = tif.res_class; e = tif.res_err; d = tif.res_depth;
  endtask

  task automatic release_result(input int hold);
    tif.res_ready = 1'b0;
    repeat (hold) begin @(posedge clk); #1; end
    tif.res_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    n_total++; if (tif.s_ready !== 1'b1) $display("FAIL %s s_ready got %b want 1", tag, tif.s_ready); else n_pass++;
    n_total++; if (tif.res_valid !== 1'b0) $display("FAIL %s res_valid got %b want 0", tag, tif.res_valid); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL %s busy got %b want 0", tag, busy); else n_pass++;
    n_total++; if (rom_addr !== '0) $display("FAIL %s rom_addr got %0d want 0", tag, rom_addr); else n_pass++;
    n_total++; if (tif.res_class !== 4'd0) $display("FAIL %s res_class got %0d want 0", tag, tif.res_class); else n_pass++;
    n_total++; if (tif.res_err !== 1'b0) $display("FAIL %s res_err got %b want 0", tag, tif.res_err); else n_pass++;
    n_total++; if (tif.res_depth !== 6'd0) $display("FAIL %s res_depth got %0d want 0", tag, tif.res_depth); else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_outputs("reset");
  endtask

  task automatic build_basic(input logic [63:0] thr, input int ltag, input int rtag);
    clear_rom();
    rom[0] = mk_node(0, 0, thr, 1, 2, 0);
    rom[1] = mk_node(1, 0, 64'd0, 0, 0, ltag);
    rom[2] = mk_node(2, 0, 64'd0, 0, 0, rtag);
  endtask

  task automatic test_basic();
    logic [63:0] fin [3] = '{D_128, D_1925, D_256};
    logic [3:0]  ecl [3] = '{4'd1, 4'd1, 4'd0};
    logic [3:0] c; logic e; logic [5:0] d; int lat;
    logic [NF*FW-1:0] fv;
    build_basic(D_1925, 1, 0);
    for (int i = 0; i < 3; i++) begin
      fv = rand_fv(); fv[63:0] = fin[i];
      run_walk(fv, c, e, d, lat);
      n_total++; if (c !== ecl[i]) $display("FAIL basic_class[%0d] got %0d want %0d", i, c, ecl[i]); else n_pass++;
      n_total++; if (e !== 1'b0) $display("FAIL basic_err[%0d] got %b want 0", i, e); else n_pass++;
      n_total++; if (d !== 6'd1) $display("FAIL basic_depth[%0d] got %0d want 1", i, d); else n_pass++;
      n_total++; if (lat != 4) $display("FAIL basic_latency[%0d] got %0d want 4", i, lat); else n_pass++;
      release_result(0);
    end
  endtask

  task automatic test_signs();
    logic [63:0] thr [7] = '{D_HALF, D_M2, D_P0, D_N0, D_M1, D_M1, D_128};
    logic [63:0] fin [7] = '{D_M1,   D_M1, D_N0, D_P0, D_M2, D_P0, D_256};
    logic [3:0]  ecl [7] = '{4'd1,   4'd2, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2};
    logic [3:0] c; logic e; logic [5:0] d; int lat;
    logic [NF*FW-1:0] fv;
    for (int i = 0; i < 7; i++) begin
      build_basic(thr[i], 1, 2);
      fv = rand_fv(); fv[63:0] = fin[i];
      run_walk(fv, c, e, d, lat);
      n_total++; if (c !== ecl[i]) $display("FAIL sign_class[%0d] got %0d want %0d", i, c, ecl[i]); else n_pass++;
      release_result(0);
    end
  endtask

  task automatic test_errors();
    int          fidx [7] = '{15, 7, 8, 0, 0, 0, 0};
    int          chld [7] = '{1, 1, 1, 511, 600, 1, 1024};
    logic        eerr [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0]  ecl  [7] = '{4'd0, 4'd5, 4'd0, 4'd9, 4'd0, 4'd5, 4'd0};
    logic [5:0]  edp  [7] = '{6'd0, 6'd1, 6'd0, 6'd1, 6'd0, 6'd1, 6'd0};
    logic [3:0] c; logic e; logic [5:0] d; int lat;
    for (int i = 0; i < 7; i++) begin
      clear_rom();
      rom[0]   = mk_node(0, fidx[i], D_128, chld[i], chld[i], 0);
      rom[1]   = mk_node(1, 0, 64'd0, 0, 0, 5);
      rom[511] = mk_node(511, 0, 64'd0, 0, 0, 9);
      run_walk(rand_fv(), c, e, d, lat);
      n_total++; if (e !== eerr[i]) $display("FAIL err_flag[%0d] got %b want %b", i, e, eerr[i]); else n_pass++;
      n_total++; if (c !== ecl[i]) $display("FAIL err_class[%0d] got %0d want %0d", i, c, ecl[i]); else n_pass++;
      n_total++; if (d !== edp[i]) $display("FAIL err_depth[%0d] got %0d want %0d", i, d, edp[i]); else n_pass++;
      n_total++; if (lat != 2*(int'(edp[i])+1)) $display("FAIL err_latency[%0d] got %0d want %0d", i, lat, 2*(int'(edp[i])+1)); else n_pass++;
      release_result(0);
    end
    clear_rom();
    rom[0] = mk_node(0, 0, D_128, 1, 1, 0);
    rom[1] = mk_node(1, 3, D_M1, 1, 1, 0);
    run_walk(rand_fv(), c, e, d, lat);
    n_total++; if (e !== 1'b1) $display("FAIL cycle_err got %b want 1", e); else n_pass++;
    n_total++; if (c !== 4'd0) $display("FAIL cycle_class got %0d want 0", c); else n_pass++;
    n_total++; if (d !== 6'd4) $display("FAIL cycle_depth got %0d want 4", d); else n_pass++;
    n_total++; if (lat != 10) $display("FAIL cycle_latency got %0d want 10", lat); else n_pass++;
    release_result(0);
  endtask

  task automatic test_back_to_back();
    logic [3:0] c; logic e; logic [5:0] d; int lat;
    logic [NF*FW-1:0] fv;
    build_basic(D_1925, 1, 0);
    tif.res_ready = 1'b0;
    fv = rand_fv(); fv[63:0] = D_128;
    run_walk(fv, c, e, d, lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_total++; if (tif.res_valid !== 1'b1) $display("FAIL hold_valid[%0d] got %b want 1", i, tif.res_valid); else n_pass++;
      n_total++; if (tif.res_class !== 4'd1) $display("FAIL hold_class[%0d] got %0d want 1", i, tif.res_class); else n_pass++;
      n_total++; if (tif.res_depth !== 6'd1) $display("FAIL hold_depth[%0d] got %0d want 1", i, tif.res_depth); else n_pass++;
      n_total++; if (tif.s_ready !== 1'b0) $display("FAIL hold_s_ready[%0d] got %b want 0", i, tif.s_ready); else n_pass++;
      n_total++; if (busy !== 1'b1) $display("FAIL hold_busy[%0d] got %b want 1", i, busy); else n_pass++;
    end
    tif.res_ready = 1'b1;
    @(posedge clk); #1;
    n_total++; if (tif.s_ready !== 1'b1) $display("FAIL release_s_ready got %b want 1", tif.s_ready); else n_pass++;
    n_total++; if (tif.res_valid !== 1'b0) $display("FAIL release_valid got %b want 0", tif.res_valid); else n_pass++;
    fv = rand_fv(); fv[63:0] = D_256;
    run_walk(fv, c, e, d, lat);
    n_total++; if (c !== 4'd0 || e !== 1'b0) $display("FAIL b2b_class got %0d/%b want 0/0", c, e); else n_pass++;
    n_total++; if (lat != 4) $display("FAIL b2b_latency got %0d want 4", lat); else n_pass++;
    release_result(0);
    fv = rand_fv(); fv[63:0] = D_M2;
    run_walk(fv, c, e, d, lat);
    n_total++; if (c !== 4'd1 || d !== 6'd1) $display("FAIL b2b2_class got %0d/%0d want 1/1", c, d); else n_pass++;
    release_result(0);
  endtask

  task automatic test_reset_mid();
    logic [3:0] c; logic e; logic [5:0] d; int lat;
    clear_rom();
    for (int a = 0; a < 4; a++) rom[a] = mk_node(a, 0, D_128, a+1, a+1, 0);
    rom[4] = mk_node(4, 0, 64'd0, 0, 0, 6);
    run_walk(rand_fv(), c, e, d, lat);
    n_total++; if (c !== 4'd6 || e !== 1'b0) $display("FAIL maxdepth_leaf got %0d/%b want 6/0", c, e); else n_pass++;
    n_total++; if (d !== 6'd4 || lat != 10) $display("FAIL maxdepth_depth got %0d/%0d want 4/10", d, lat); else n_pass++;
    release_result(0);
    tif.s_valid = 1'b1; tif.feat_in = rand_fv();
    @(posedge clk); #1;
    tif.s_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    n_total++; if (rom_addr !== 10'd3 || busy !== 1'b1) $display("FAIL mid_walk got addr %0d busy %b want 3/1", rom_addr, busy); else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_outputs("reset_mid");
    run_walk(rand_fv(), c, e, d, lat);
    n_total++; if (c !== 4'd6 || d !== 6'd4 || e !== 1'b0) $display("FAIL after_reset got %0d/%0d/%b want 6/4/0", c, d, e); else n_pass++;
    release_result(0);
  endtask

  task automatic test_node_id();
    logic [3:0] c; logic e; logic [5:0] d; int lat;
    logic [NF*FW-1:0] fv;
    logic [3:0] want_c; logic want_e;
    build_basic(D_1925, 1, 3);
    rom[2] = mk_node(12'h102, 0, 64'd0, 0, 0, 3);
    fv = rand_fv(); fv[63:0] = D_256;
`ifdef TREE_NODE_ID_CHECK_EN
    want_c = 4'd0; want_e = 1'b1;
`else
    want_c = 4'd3; want_e = 1'b0;
`endif
    run_walk(fv, c, e, d, lat);
    n_total++; if (c !== want_c || e !== want_e) $display("FAIL node_id got %0d/%b want %0d/%b", c, e, want_c, want_e); else n_pass++;
    n_total++; if (d !== 6'd1) $display("FAIL node_id_depth got %0d want 1", d); else n_pass++;
    release_result(0);
  endtask

  task automatic test_random();
    logic [3:0] c, ec; logic e, ee; logic [5:0] d, ed; int lat;
    logic [NF*FW-1:0] fv;
    int id, fidx, l, r;
    for (int t = 0; t < 6; t++) begin
      clear_rom();
      for (int a = 0; a < 32; a++) begin
`ifdef TREE_NODE_ID_CHECK_EN
        id = a;
`else
        id = $urandom_range(0, 4095);
`endif
        if ($urandom_range(0, 99) < 35) begin
          rom[a] = mk_node(id, $urandom_range(0, 15), pick(), 0, 0, $urandom_range(0, 15));
        end else begin
          fidx = ($urandom_range(0, 9) == 0) ? $urandom_range(8, 15) : $urandom_range(0, 7);
          l = ($urandom_range(0, 19) == 0) ? $urandom_range(512, 4095) : $urandom_range(0, 31);
          r = ($urandom_range(0, 19) == 0) ? $urandom_range(512, 4095) : $urandom_range(0, 31);
          rom[a] = mk_node(id, fidx, pick(), l, r, $urandom_range(0, 15));
        end
      end
      for (int v = 0; v < 8; v++) begin
        fv = rand_fv();
        model(fv, ec, ee, ed);
        run_walk(fv, c, e, d, lat);
        n_total++; if (c !== ec) $display("FAIL rand_class[%0d.%0d] got %0d want %0d", t, v, c, ec); else n_pass++;
        n_total++; if (e !== ee) $display("FAIL rand_err[%0d.%0d] got %b want %b", t, v, e, ee); else n_pass++;
        n_total++; if (d !== ed) $display("FAIL rand_depth[%0d.%0d] got %0d want %0d", t, v, d, ed); else n_pass++;
        n_total++; if (lat != 2*(int'(ed)+1)) $display("FAIL rand_latency[%0d.%0d] got %0d want %0d", t, v, lat, 2*(int'(ed)+1)); else n_pass++;
        release_result($urandom_range(0, 2));
      end
    end
  endtask

  initial begin
    pool[0]  = D_P0;  pool[1]  = D_N0;  pool[2]  = D_HALF; pool[3]  = D_M1;
    pool[4]  = D_M2;  pool[5]  = D_128; pool[6]  = D_1925; pool[7]  = D_256;
    pool[8]  = 64'h0000000000000001; pool[9]  = 64'h8000000000000001;
    pool[10] = 64'h7FEFFFFFFFFFFFFF; pool[11] = 64'hFFEFFFFFFFFFFFFF;
    rst = 1'b1;
    tif.s_valid = 1'b0;
    tif.res_ready = 1'b1;
    tif.feat_in = '0;
    clear_rom();
    test_reset();
    test_basic();
    test_signs();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    test_node_id();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
